sa_sync_evt_arb: RTL and testbench
==================================

// Module: sa_sync_evt_arb
// PURPOSE
//  Event scheduler for a bank of 3-stage set-type synchronizers. Each channel is a
//  toggle-encoded request from another clock domain, already resynchronized into clk.
//  The block detects toggles and counts them per channel. It arbitrates pending events
//  round-robin onto one valid/ready event port, and returns a per-channel ack toggle
//  that the source domain resynchronizes.
// PARAMETERS
//  N        4   number of request channels
//  ID_W     2   width of evt_id; 2**ID_W >= N required
//  CNT_W    4   per-channel pending counter width, saturating
//  RST_VAL  1   reset value of toggle history; matches the set-type synchronizer reset value
// PORTS
//  clk           in   1      core clock, single domain
//  rst           in   1      synchronous reset, active-high
//  cfg_en        in   1      1 = new offers may be issued
//  cfg_clr       in   1      1-cycle pulse: clear all counters and ovf
//  req_tgl_sync  in   N      synchronized request toggles, one per channel
//  ack_tgl       out  N      ack toggles, one flip per accepted event
//  evt_valid     out  1      event offered
//  evt_ready     in   1      consumer accepts when evt_valid & evt_ready
//  evt_id        out  ID_W   channel index of the offered event
//  pend_any      out  1      OR over channels of (cnt != 0)
//  ovf           out  N      sticky: toggle arrived while counter saturated
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - tgl_prev = {N{RST_VAL}}, cnt = 0, ack_tgl = 0, ovf = 0.
//   - evt_valid = 0, evt_id = 0, state = IDLE, rr_ptr = 0.
//   - Reset takes effect mid-offer; the offer is dropped without an ack.
//  Toggle detect:
//   - tgl[i] = req_tgl_sync[i] ^ tgl_prev[i]; tgl_prev <= req_tgl_sync every cycle.
//   - Counting is independent of cfg_en.
//  Counter update per channel, per cycle:
//   - +1 on tgl[i]; -1 on accept of channel i; both together: no change.
//   - Increment at 2**CNT_W-1 holds the count and sets ovf[i]; ovf clears only on rst or cfg_clr.
//   - Decrement never goes below 0.
//  cfg_clr:
//   - Sets cnt and ovf to 0; a toggle in the same cycle is discarded.
//   - An in-flight offer stays valid until accepted; its decrement floors at 0.
//   - The ack still toggles on accept.
//  FSM IDLE -> OFFER:
//   - Taken when cfg_en=1 and some cnt != 0, using registered counts.
//   - Grant = first channel with cnt != 0 searching rr_ptr, rr_ptr+1, ... mod N.
//   - Next cycle: evt_valid=1, evt_id=grant, rr_ptr=(grant+1) mod N.
//  FSM OFFER -> IDLE:
//   - Taken on evt_valid & evt_ready.
//   - Next cycle: evt_valid=0, cnt[id] decremented, ack_tgl[id] flipped.
//   - One bubble cycle between offers; max throughput is 1 event per 2 cycles.
//  Offer stability: evt_valid and evt_id are stable in OFFER until accepted.
//   - cfg_en=0 does not withdraw an offer.
//  Latency from req_tgl_sync edge (cycle t) with the block idle:
//   - cnt updates at t+1; evt_valid first high in cycle t+2.
//  Outputs: all are registered except pend_any, which is derived from registered counts.
// TESTING
//  1 Reset: rst with req_tgl_sync=4'hF
//     -> no toggles detected, cnt=0, evt_valid=0, ack_tgl=0.
//  2 Single event: ch2 toggles at cycle t, evt_ready=1
//     -> evt_valid at t+2 with evt_id=2; accepted; ack_tgl[2] flips at t+3; cnt[2]=0.
//  3 Round robin: ch0, ch1, ch3 pending at once, evt_ready=1
//     -> ids 0, 1, 3 in order, each valid pulse followed by one bubble cycle.
//  4 Saturation: ch1 toggles 17 times with cfg_en=0, CNT_W=4
//     -> cnt[1]=15, ovf[1]=1; with cfg_en=1, exactly 15 events are issued.
//  5 Backpressure and simultaneity: offer for ch0 held 5 cycles with evt_ready=0,
//    and ch0 toggles in the accept cycle
//     -> evt_id stays 0 while held; cnt[0] is unchanged by the accept cycle.
//  6 Clear mid-offer: cfg_clr while OFFER on ch3 with cnt[3]=2
//     -> offer completes, cnt[3]=0 (no underflow), ack_tgl[3] flips, no further offers.

Source files
------------

// File: rtl/sa_sync_evt_arb.sv
// Toggle-event scheduler for a bank of resynchronized request channels.
// Counts toggles per channel and offers them round-robin on a valid/ready port.
module sa_sync_evt_arb #(
  parameter int   N       = 4,
  parameter int   ID_W    = 2,
  parameter int   CNT_W   = 4,
  parameter logic RST_VAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cfg_en_i,
  input  logic            cfg_clr_i,
  input  logic [N-1:0]    req_tgl_sync_i,
  output logic [N-1:0]    ack_tgl_o,
  output logic            evt_valid_o,
  input  logic            evt_ready_i,
  output logic [ID_W-1:0] evt_id_o,
  output logic            pend_any_o,
  output logic [N-1:0]    ovf_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [N-1:0]      tgl_prev_q;
  logic [CNT_W-1:0]  cnt_q [N];
  logic [CNT_W-1:0]  cnt_d [N];
  logic [N-1:0]      ovf_q, ovf_d;
  logic [N-1:0]      ack_q, ack_d;
  logic              evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d;
  logic [ID_W-1:0]   rr_q, rr_d;

  logic [N-1:0]      tgl_s;
  logic [N-1:0]      dec_s;
  logic [N-1:0]      nz_s;
  logic              accept_s;
  logic [ID_W-1:0]   grant_s;
  logic              found_s;
  int                idx_s;

  assign tgl_s    = req_tgl_sync_i ^ tgl_prev_q;
  assign accept_s = evt_valid_q & evt_ready_i;

  always_comb begin
    dec_s = '0;
    nz_s  = '0;
    for (int i = 0; i < N; i++) begin
      nz_s[i]  = (cnt_q[i] != '0);
      dec_s[i] = accept_s && (evt_id_q == ID_W'(i));
    end
  end

  assign pend_any_o = |nz_s;

  // A toggle and an accept on the same channel cancel; clear wins over both.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cfg_clr_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (tgl_s[i] && dec_s[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (tgl_s[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else if (dec_s[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(rr_q) + k) % N;
      if (!found_s && nz_s[idx_s]) begin
        found_s = 1'b1;
        grant_s = ID_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_d        = rr_q;
    ack_d       = ack_q;
    case (state_q)
      IDLE: begin
        if (cfg_en_i && found_s) begin
          state_d     = OFFER;
          evt_valid_d = 1'b1;
          evt_id_d    = grant_s;
          rr_d        = (grant_s == ID_W'(N-1)) ? '0 : grant_s + {{(ID_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = IDLE;
        end
      end
      OFFER: begin
        // The offer is held regardless of cfg_en until the consumer takes it.
        if (accept_s) begin
          state_d     = IDLE;
          evt_valid_d = 1'b0;
          ack_d       = ack_q ^ (ONE_N << evt_id_q);
        end else begin
          state_d = OFFER;
        end
      end
      default: begin
        state_d     = IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tgl_prev_q  <= {N{RST_VAL}};
      ovf_q       <= '0;
      ack_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_q        <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tgl_prev_q  <= req_tgl_sync_i;
      ovf_q       <= ovf_d;
      ack_q       <= ack_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_q        <= rr_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign ack_tgl_o   = ack_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_sa_sync_evt_arb.sv
// Directed bench for sa_sync_evt_arb: a cycle table for reset, single event and
// round robin, then hand sequences for saturation, backpressure and clear.
module tb_sa_sync_evt_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_en;
  logic       cfg_clr;
  logic [3:0] req;
  logic [3:0] ack;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       pend_any;
  logic [3:0] ovf;

  int n_checks = 0;
  int n_errors = 0;

  sa_sync_evt_arb #(.N(4), .ID_W(2), .CNT_W(4), .RST_VAL(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_en_i       (cfg_en),
    .cfg_clr_i      (cfg_clr),
    .req_tgl_sync_i (req),
    .ack_tgl_o      (ack),
    .evt_valid_o    (evt_valid),
    .evt_ready_i    (evt_ready),
    .evt_id_o       (evt_id),
    .pend_any_o     (pend_any),
    .ovf_o          (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    logic [1:0] id;
    logic [3:0] ack;
    logic       pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'hF; rst = 1'b1; cfg_en = 1'b0; cfg_clr = 1'b0; evt_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int ev_cnt;
  int bad_id;
  int stray;

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_clr = 1'b0; req = 4'hF; evt_ready = 1'b0;

    //           rst   en    clr   req   rdy   ev    id    ack   pend  ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'hB, 1'b1, 1'b1, 2'd2, 4'h0, 1'b1, 4'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 2'd2, 4'h4, 1'b0, 4'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 2'd2, 4'h4, 1'b0, 4'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1, 2'd0, 4'h0, 1'b1, 4'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'h1, 1'b1, 4'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1, 2'd1, 4'h1, 1'b1, 4'h0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 2'd1, 4'h3, 1'b1, 4'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1, 2'd3, 4'h3, 1'b1, 4'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 2'd3, 4'hB, 1'b0, 4'h0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0, 2'd3, 4'hB, 1'b0, 4'h0};

    // Reset, single event on ch2, then round robin over ch0/ch1/ch3.
    for (int v = 0; v < 17; v++) begin
      rst = vecs[v].rst; cfg_en = vecs[v].en; cfg_clr = vecs[v].clr;
      req = vecs[v].req; evt_ready = vecs[v].rdy;
      tick();
      chk($sformatf("vec%0d valid", v), 32'(evt_valid), 32'(vecs[v].ev));
      chk($sformatf("vec%0d ack", v), 32'(ack), 32'(vecs[v].ack));
      chk($sformatf("vec%0d pend", v), 32'(pend_any), 32'(vecs[v].pend));
      chk($sformatf("vec%0d ovf", v), 32'(ovf), 32'(vecs[v].ovf));
      if (vecs[v].ev) chk($sformatf("vec%0d id", v), 32'(evt_id), 32'(vecs[v].id));
    end

    // Saturation: 17 toggles on ch1 with offers disabled.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      req[1] = ~req[1];
      tick();
      if (k == 15) chk("sat ovf before full", 32'(ovf), 32'h0);
      if (k == 16) chk("sat ovf set", 32'(ovf), 32'h2);
    end
    chk("sat no offer while disabled", 32'(evt_valid), 32'h0);
    chk("sat pend", 32'(pend_any), 32'h1);
    cfg_en = 1'b1; evt_ready = 1'b1;
    ev_cnt = 0; bad_id = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (evt_valid) begin
        ev_cnt++;
        if (evt_id != 2'd1) bad_id++;
      end
    end
    chk("sat event count", 32'(ev_cnt), 32'd15);
    chk("sat event ids", 32'(bad_id), 32'd0);
    chk("sat drained pend", 32'(pend_any), 32'h0);
    chk("sat ovf sticky", 32'(ovf), 32'h2);
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
    chk("clr ovf", 32'(ovf), 32'h0);

    // Backpressure: hold the ch0 offer, then toggle ch0 in the accept cycle.
    do_reset();
    cfg_en = 1'b1; evt_ready = 1'b0; req = 4'hE;
    tick();
    tick();
    chk("bp offer valid", 32'(evt_valid), 32'h1);
    chk("bp offer id", 32'(evt_id), 32'h0);
    for (int h = 0; h < 5; h++) begin
      cfg_en = (h >= 2) ? 1'b0 : 1'b1;
      tick();
      chk($sformatf("bp hold%0d valid", h), 32'(evt_valid), 32'h1);
      chk($sformatf("bp hold%0d id", h), 32'(evt_id), 32'h0);
    end
    cfg_en = 1'b1; evt_ready = 1'b1; req = 4'hF;
    tick();
    chk("bp accept valid", 32'(evt_valid), 32'h0);
    chk("bp accept ack", 32'(ack), 32'h1);
    chk("bp cnt kept", 32'(pend_any), 32'h1);
    evt_ready = 1'b0;
    tick();
    chk("bp reoffer valid", 32'(evt_valid), 32'h1);
    chk("bp reoffer id", 32'(evt_id), 32'h0);
    evt_ready = 1'b1;
    tick();
    chk("bp second ack", 32'(ack), 32'h0);
    chk("bp final pend", 32'(pend_any), 32'h0);

    // Clear mid-offer on ch3 with two pending.
    do_reset();
    req = 4'h7;
    tick();
    req = 4'hF;
    tick();
    chk("clr pre pend", 32'(pend_any), 32'h1);
    cfg_en = 1'b1; evt_ready = 1'b0;
    tick();
    chk("clr offer valid", 32'(evt_valid), 32'h1);
    chk("clr offer id", 32'(evt_id), 32'h3);
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
    chk("clr keeps offer", 32'(evt_valid), 32'h1);
    chk("clr keeps id", 32'(evt_id), 32'h3);
    chk("clr zero pend", 32'(pend_any), 32'h0);
    evt_ready = 1'b1;
    tick();
    chk("clr accept valid", 32'(evt_valid), 32'h0);
    chk("clr accept ack", 32'(ack), 32'h8);
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (evt_valid || pend_any) stray++;
    end
    chk("clr no further offers", 32'(stray), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
